// File: rtl/banked_spram_pm_pkg.sv
// Shared constants and helpers for the banked single-port RAM with per-bank power management.
// Power management is compiled in only when BANK_PM_EN is defined.
package banked_spram_pm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ACTIVE  = 3'd0,
    ST_STANDBY = 3'd1,
    ST_SLEEP   = 3'd2,
    ST_WAKE    = 3'd3,
    ST_OFF     = 3'd4
  } pm_state_e;

  // Ceiling log2, usable in constant expressions for index widths.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/banked_spram_pm_if.sv
// Requester-side bus of banked_spram_pm: access handshake, read return and power controls/status.
interface banked_spram_pm_if
  import banked_spram_pm_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_ADDR_W = 14,
  parameter int unsigned DATA_W      = 32
) ();

  localparam int unsigned BANK_W = clog2_f(NUM_BANKS);
  localparam int unsigned ADDR_W = BANK_ADDR_W + BANK_W;

  logic                         req;
  logic                         we;
  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            wdata;
  logic [DATA_W/4-1:0]          mask_wren;
  logic [NUM_BANKS-1:0]         poweroff_req;
  logic                         ready;
  logic [DATA_W-1:0]            rdata;
  logic                         rvalid;
  logic [STATE_W*NUM_BANKS-1:0] bank_state;

  modport master (
    output req, we, addr, wdata, mask_wren, poweroff_req,
    input  ready, rdata, rvalid, bank_state
  );

  modport slave (
    input  req, we, addr, wdata, mask_wren, poweroff_req,
    output ready, rdata, rvalid, bank_state
  );

endinterface

// File: rtl/banked_spram_pm_bank_pm_ctrl.sv
// Per-bank power FSM with idle and wake counters (BANK_PM_EN); without it the bank is pinned ACTIVE.
module bank_pm_ctrl
  import banked_spram_pm_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES  = 16,
  parameter int unsigned SLEEP_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES  = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_req_hit,
  input  logic      i_accept,
  input  logic      i_poweroff,
  output pm_state_e o_state,
  output logic      o_active_c
);

`ifdef BANK_PM_EN
  localparam int unsigned CNT_MAX = (IDLE_CYCLES > SLEEP_CYCLES) ? IDLE_CYCLES : SLEEP_CYCLES;
  localparam int unsigned CNT_W   = clog2_f(CNT_MAX + 1);
  localparam int unsigned WAKE_W  = 4;

  pm_state_e          r_state;
  pm_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_idle_cnt;
  logic [CNT_W-1:0]   w_idle_nxt;
  logic [WAKE_W-1:0]  r_wake_cnt;
  logic [WAKE_W-1:0]  w_wake_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
    end
  end

  // Counters only increment below their threshold, so they saturate rather than wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = r_wake_cnt;
    if (i_poweroff) begin
      w_state_nxt = ST_OFF;
      w_idle_nxt  = '0;
      w_wake_nxt  = '0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (i_accept) begin
            w_idle_nxt = '0;
          end else if (r_idle_cnt >= CNT_W'(IDLE_CYCLES - 1)) begin
            w_state_nxt = ST_STANDBY;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + CNT_W'(1);
          end
        end
        ST_STANDBY: begin
          if (i_req_hit) begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = '0;
          end else if (r_idle_cnt >= CNT_W'(SLEEP_CYCLES - 1)) begin
            w_state_nxt = ST_SLEEP;
            w_idle_nxt  = '0;
          end else begin
            w_idle_nxt = r_idle_cnt + CNT_W'(1);
          end
        end
        ST_SLEEP, ST_OFF: begin
          if (i_req_hit) begin
            w_state_nxt = ST_WAKE;
            w_wake_nxt  = '0;
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt >= WAKE_W'(WAKE_CYCLES - 1)) begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = '0;
            w_wake_nxt  = '0;
          end else begin
            w_wake_nxt = r_wake_cnt + WAKE_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_ACTIVE;
          w_idle_nxt  = '0;
          w_wake_nxt  = '0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_active_c = (r_state == ST_ACTIVE);
`else
  logic w_unused_pm;
  assign w_unused_pm = ^{clk, reset, i_req_hit, i_accept, i_poweroff};
  assign o_state     = ST_ACTIVE;
  assign o_active_c  = 1'b1;
`endif

endmodule

// File: rtl/banked_spram_pm.sv
// Multi-bank single-port RAM; addr MSBs pick the bank, each bank has its own power controller.
// Define BANK_PM_EN to enable the power FSMs, ready stalls and poweroff_req.
module banked_spram_pm
  import banked_spram_pm_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned BANK_ADDR_W  = 14,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned IDLE_CYCLES  = 16,
  parameter int unsigned SLEEP_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES  = 2
) (
  input logic               clk,
  input logic               reset,
  banked_spram_pm_if.slave  bus
);

  localparam int unsigned BANK_W = clog2_f(NUM_BANKS);
  localparam int unsigned ADDR_W = BANK_ADDR_W + BANK_W;
  localparam int unsigned NIB_N  = DATA_W / 4;
  localparam int unsigned DEPTH  = 1 << BANK_ADDR_W;

  logic [BANK_W-1:0]      w_bank_sel;
  logic [BANK_ADDR_W-1:0] w_offset;
  logic                   w_accept;
  logic [NUM_BANKS-1:0]   w_active;
  logic [DATA_W-1:0]      w_rd_word [NUM_BANKS];
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rvalid;

  assign w_bank_sel = bus.addr[ADDR_W-1 -: BANK_W];
  assign w_offset   = bus.addr[BANK_ADDR_W-1:0];
  assign w_accept   = bus.req && bus.ready;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_hit;
    pm_state_e         w_state;

    assign w_hit = (w_bank_sel == BANK_W'(b));

    bank_pm_ctrl #(
      .IDLE_CYCLES  (IDLE_CYCLES),
      .SLEEP_CYCLES (SLEEP_CYCLES),
      .WAKE_CYCLES  (WAKE_CYCLES)
    ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .i_req_hit  (bus.req && w_hit),
      .i_accept   (w_accept && w_hit),
      .i_poweroff (bus.poweroff_req[b]),
      .o_state    (w_state),
      .o_active_c (w_active[b])
    );

    assign bus.bank_state[STATE_W*b +: STATE_W] = w_state;

    // Nibble-masked write port; storage itself is never reset.
    always_ff @(posedge clk) begin
      if (w_accept && bus.we && w_hit) begin
        for (int unsigned i = 0; i < NIB_N; i++) begin
          if (bus.mask_wren[i]) r_mem[w_offset][4*i +: 4] <= bus.wdata[4*i +: 4];
        end
      end
    end

    assign w_rd_word[b] = r_mem[w_offset];
  end

`ifdef BANK_PM_EN
  assign bus.ready = bus.req && w_active[w_bank_sel];
`else
  // Every bank is pinned active, so this is constant high.
  assign bus.ready = &w_active;
`endif

  // Bank selected at acceptance; rdata holds until the next read returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_accept && !bus.we;
      if (w_accept && !bus.we) r_rdata <= w_rd_word[w_bank_sel];
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_banked_spram_pm.sv
// Directed bench for banked_spram_pm (4 banks, idle 8, sleep 32, wake 3); follows BANK_PM_EN.
module tb_banked_spram_pm;
  import banked_spram_pm_pkg::*;

`ifdef BANK_PM_EN
  localparam int PM = 1;
`else
  localparam int PM = 0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   stalls;
  int   last_st;

  banked_spram_pm_if #(.NUM_BANKS(4), .BANK_ADDR_W(14), .DATA_W(32)) bus ();

  banked_spram_pm #(
    .NUM_BANKS    (4),
    .BANK_ADDR_W  (14),
    .DATA_W       (32),
    .IDLE_CYCLES  (8),
    .SLEEP_CYCLES (32),
    .WAKE_CYCLES  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] st(input int b);
    return bus.bank_state[3*b +: 3];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [7:0] m);
    bus.req       = r;
    bus.we        = w;
    bus.addr      = a;
    bus.wdata     = d;
    bus.mask_wren = m;
    #1;
  endtask

  // Hold the current request until ready, counting stall cycles and the last stalled state of bank b.
  task automatic wait_ready(input string tag, input int b, input int budget,
                            output int n, output int last);
    n    = 0;
    last = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.ready) break;
      last = 32'(st(b));
      n++;
      cyc();
    end
    chk({tag, "_ready_seen"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.poweroff_req = '0;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    repeat (3) cyc();

    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_state", 32'(bus.bank_state), 32'h0);
    chk("rst_ready_noreq", 32'(bus.ready), 32'(PM ? 0 : 1));
    drive(1'b1, 1'b0, 16'h8000, 32'h0, 8'h0);
    chk("rst_ready_req", 32'(bus.ready), 32'd1);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    reset = 1'b0;

    // Full write then read-back next cycle
    drive(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 8'hFF);
    chk("a_wr_ready", 32'(bus.ready), 32'd1);
    cyc();
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 8'h0);
    chk("a_rd_ready", 32'(bus.ready), 32'd1);
    chk("a_wr_no_rvalid", 32'(bus.rvalid), 32'd0);
    cyc();
    chk("a_rvalid", 32'(bus.rvalid), 32'd1);
    chk("a_rdata", bus.rdata, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    cyc();
    chk("a_rvalid_pulse", 32'(bus.rvalid), 32'd0);
    chk("a_rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Nibble mask merge
    drive(1'b1, 1'b1, 16'h0020, 32'hFFFFFFFF, 8'hFF);
    cyc();
    drive(1'b1, 1'b1, 16'h0020, 32'h12345678, 8'h0F);
    cyc();
    drive(1'b1, 1'b0, 16'h0020, 32'h0, 8'h0);
    cyc();
    chk("b_rvalid", 32'(bus.rvalid), 32'd1);
    chk("b_rdata_mask", bus.rdata, 32'hFFFF5678);

    // Back-to-back reads across banks
    drive(1'b1, 1'b1, 16'h4005, 32'hCAFEF00D, 8'hFF);
    chk("x_wr_ready", 32'(bus.ready), 32'd1);
    cyc();
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 8'h0);
    cyc();
    drive(1'b1, 1'b0, 16'h4005, 32'h0, 8'h0);
    chk("x_rdata_b0", bus.rdata, 32'hDEADBEEF);
    cyc();
    chk("x_rvalid_b1", 32'(bus.rvalid), 32'd1);
    chk("x_rdata_b1", bus.rdata, 32'hCAFEF00D);

    // Bank 2 sleeps after 8+32 idle cycles and keeps its contents
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    cyc();
    reset = 1'b0;
    drive(1'b1, 1'b1, 16'h8007, 32'h0BADF00D, 8'hFF);
    chk("c_wr_ready", 32'(bus.ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    repeat (7) cyc();
    chk("c_b2_active7", 32'(st(2)), 32'd0);
    cyc();
    chk("c_b2_standby8", 32'(st(2)), 32'(PM ? 1 : 0));
    repeat (31) cyc();
    chk("c_b2_standby39", 32'(st(2)), 32'(PM ? 1 : 0));
    cyc();
    chk("c_b2_sleep40", 32'(st(2)), 32'(PM ? 2 : 0));
    chk("c_b0_sleep", 32'(st(0)), 32'(PM ? 2 : 0));
    drive(1'b1, 1'b0, 16'h8007, 32'h0, 8'h0);
    chk("c_ready_low", 32'(bus.ready), 32'(PM ? 0 : 1));
    wait_ready("c", 2, 20, stalls, last_st);
    chk("c_stalls", 32'(stalls), 32'(PM ? 4 : 0));
    chk("c_last_wake", 32'(last_st), 32'(PM ? 3 : 0));
    cyc();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    chk("c_rvalid", 32'(bus.rvalid), 32'd1);
    chk("c_rdata_retained", bus.rdata, 32'h0BADF00D);
    chk("c_b2_active", 32'(st(2)), 32'd0);

    // Access on the idle expiry edge keeps bank 1 active
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (7) cyc();
    drive(1'b1, 1'b1, 16'h4001, 32'h11112222, 8'hFF);
    chk("d_ready", 32'(bus.ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    chk("d_b1_active", 32'(st(1)), 32'd0);
    chk("d_b0_standby", 32'(st(0)), 32'(PM ? 1 : 0));
    repeat (7) cyc();
    chk("d_b1_still_active", 32'(st(1)), 32'd0);
    cyc();
    chk("d_b1_standby", 32'(st(1)), 32'(PM ? 1 : 0));

    // Power-off holds bank 3 off even with a pending request
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.poweroff_req = 4'b1000;
    cyc();
    drive(1'b1, 1'b0, 16'hC003, 32'h0, 8'h0);
    for (int i = 0; i < 5; i++) begin
      chk("e_ready_off", 32'(bus.ready), 32'(PM ? 0 : 1));
      cyc();
    end
    chk("e_b3_off", 32'(st(3)), 32'(PM ? 4 : 0));
    bus.poweroff_req = '0;
    #1;
    wait_ready("e", 3, 20, stalls, last_st);
    chk("e_stalls", 32'(stalls), 32'(PM ? 4 : 0));
    chk("e_last_wake", 32'(last_st), 32'(PM ? 3 : 0));
    cyc();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    chk("e_rvalid", 32'(bus.rvalid), 32'd1);

    // Reset during bank 2 WAKE drops the pending access
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.poweroff_req = 4'b0100;
    cyc();
    bus.poweroff_req = '0;
    drive(1'b1, 1'b0, 16'h8003, 32'h0, 8'h0);
    cyc();
    chk("f_b2_wake", 32'(st(2)), 32'(PM ? 3 : 0));
    chk("f_ready_wake", 32'(bus.ready), 32'(PM ? 0 : 1));
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 8'h0);
    cyc();
    chk("f_rst_state", 32'(bus.bank_state), 32'h0);
    chk("f_rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("f_rst_rdata", bus.rdata, 32'h0);
    chk("f_rst_ready", 32'(bus.ready), 32'(PM ? 0 : 1));
    reset = 1'b0;
    cyc();
    chk("f_no_rvalid", 32'(bus.rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
